rtype_sequencer: RTL and testbench
==================================

RTYPE_SEQUENCER -- requirements
Module: rtype_sequencer

Interface
REQ-001 Parameter RETIRE_W, default 16, sets the width of the retired-instruction counter.
REQ-002 Port clk, input, 1, is the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1, is the reset; it SHALL be synchronous and active-high.
REQ-004 Port instr_valid, input, 1, SHALL mean that instr holds an instruction offered for issue.
REQ-005 Port instr, input, 32, SHALL carry the MIPS R-type word: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
REQ-006 Port instr_ready, output, 1, SHALL mean the sequencer accepts an instruction this cycle.
REQ-007 Ports rf_ra and rf_rb, output, 5 each, SHALL be the register-file read addresses.
REQ-008 Port rf_re, output, 1, SHALL be the register-file read strobe.
REQ-009 Port alu_op, output, 3, SHALL be the ALU operation select; port shamt_o, output, 5, SHALL be the shift amount.
REQ-010 Port rf_wa, output, 5, SHALL be the write-back address; port rf_we, output, 1, SHALL be the write strobe.
REQ-011 Port busy, output, 1, SHALL be high whenever the state is not IDLE.
REQ-012 Port illegal, output, 1, SHALL be a one-cycle pulse that flags a rejected instruction.
REQ-013 Port retired, output, RETIRE_W, SHALL count instructions that completed WB.

Function
REQ-014 The FSM SHALL have states IDLE, DECODE, READ, EXEC and WB.
REQ-015 instr_ready SHALL equal 1 only in IDLE; a handshake (instr_valid and instr_ready) SHALL latch instr and move the FSM to DECODE.
REQ-016 The latched word SHALL be the only source for later stages; changes on instr after acceptance SHALL have no effect.
REQ-017 Funct decode, with opcode 0, SHALL be:
- 100000 add -> alu_op 0
- 100010 sub -> 1
- 100100 and -> 2
- 100101 or -> 3
- 101010 slt -> 4
- 000000 sll -> 5
- 000010 srl -> 6
REQ-018 In DECODE, a nonzero opcode or an unlisted funct SHALL pulse illegal for one cycle and return the FSM to IDLE with no read and no write.
REQ-019 READ (one cycle) SHALL assert rf_re:
- non-shift ops: rf_ra=rs, rf_rb=rt
- shift ops: rf_ra=rt, rf_rb=0
REQ-020 EXEC (one cycle) SHALL drive alu_op; shamt_o SHALL be the latched shamt for shifts and 0 otherwise.
REQ-021 WB (one cycle) SHALL drive rf_wa=rd and assert rf_we, except when rd=0, where rf_we SHALL stay 0; in both cases retired SHALL increment, then the FSM SHALL go to IDLE.
REQ-022 Latency: an instruction accepted in cycle N SHALL have READ at N+2, EXEC at N+3 and WB at N+4, and SHALL next be ready at N+5.
REQ-023 rf_re, rf_we and illegal SHALL be 0 outside their states; address and ALU outputs SHALL be 0 when not in use.
REQ-024 Don't-care fields SHALL NOT affect any output, including when they are X: rs and rd-independent bits for shifts, shamt for non-shift ops.
REQ-025 retired SHALL wrap from all-ones to 0.

Reset
REQ-026 With rst high at a clock edge, the FSM SHALL go to IDLE and the latched word, retired and all outputs SHALL clear to 0, except instr_ready, which SHALL become 1 in the first cycle after reset.
REQ-027 A reset arriving mid-instruction, including during WB, SHALL suppress that instruction's rf_we and SHALL NOT increment retired.

Configuration
REQ-028 Macro RTYPE_SHIFT_EN defined SHALL enable sll/srl per REQ-017, REQ-019 and REQ-020; undefined, funct 000000 and 000010 SHALL be illegal per REQ-018.

Verification
REQ-029 Reset, then add r2=r0+r2 (rs=0, rt=2, rd=2): READ has ra=0, rb=2, re=1; EXEC alu_op=0; WB wa=2, we=1; retired=1; ready again 5 cycles after accept.
REQ-030 With macro defined, sll rd=2, rt=0, shamt=2, rs=X: READ ra=0, rb=0; EXEC alu_op=5, shamt_o=2; no X on any output.
REQ-031 Opcode 000100, or funct 111111: illegal pulses at N+1, no rf_re/rf_we, retired unchanged; without the macro, sll gives the same response.
REQ-032 add with rd=0: WB occurs with rf_we=0 and retired increments; instr toggled after accept changes nothing.
REQ-033 rst asserted in EXEC: next cycle is IDLE, all outputs 0, no write; preload retired to all-ones and retire one instruction -> retired=0.

Source files
------------

// File: rtl/rtype_sequencer.sv
// rtype_sequencer: multi-cycle issue sequencer for MIPS R-type words.
// Accepts one instruction in IDLE, then walks DECODE, READ, EXEC and WB.
// Illegal words are rejected in DECODE with a one-cycle pulse.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   instr_valid     an instruction is offered on instr
//   instr[31:0]     opcode|rs|rt|rd|shamt|funct
//   instr_ready     sequencer accepts this cycle (IDLE only)
//   rf_ra, rf_rb    register-file read addresses
//   rf_re           register-file read strobe (READ)
//   alu_op, shamt_o ALU select and shift amount (EXEC)
//   rf_wa, rf_we    write-back address and strobe (WB)
//   busy            state is not IDLE
//   illegal         one-cycle rejection pulse (DECODE)
//   retired         count of instructions that completed WB, wraps
// Options: define RTYPE_SHIFT_EN to accept sll/srl; otherwise they are illegal.
module rtype_sequencer #(
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    input  logic [31:0]         instr,
    output logic                instr_ready,
    output logic [4:0]          rf_ra,
    output logic [4:0]          rf_rb,
    output logic                rf_re,
    output logic [2:0]          alu_op,
    output logic [4:0]          shamt_o,
    output logic [4:0]          rf_wa,
    output logic                rf_we,
    output logic                busy,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        READ   = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         instr_q, instr_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd, shamt;

    assign opcode = instr_q[31:26];
    assign rs     = instr_q[25:21];
    assign rt     = instr_q[20:16];
    assign rd     = instr_q[15:11];
    assign shamt  = instr_q[10:6];
    assign funct  = instr_q[5:0];

    // Decode depends only on opcode and funct, so unknown rs/rd/shamt
    // bits in the latched word cannot disturb legality or the op select.
    logic       legal;
    logic       is_shift;
    logic [2:0] dec_op;

    always_comb begin
        legal    = 1'b0;
        is_shift = 1'b0;
        dec_op   = 3'd0;
        if (opcode == 6'd0) begin
            case (funct)
                6'b100000: begin legal = 1'b1; dec_op = 3'd0; end
                6'b100010: begin legal = 1'b1; dec_op = 3'd1; end
                6'b100100: begin legal = 1'b1; dec_op = 3'd2; end
                6'b100101: begin legal = 1'b1; dec_op = 3'd3; end
                6'b101010: begin legal = 1'b1; dec_op = 3'd4; end
`ifdef RTYPE_SHIFT_EN
                6'b000000: begin
                    legal    = 1'b1;
                    is_shift = 1'b1;
                    dec_op   = 3'd5;
                end
                6'b000010: begin
                    legal    = 1'b1;
                    is_shift = 1'b1;
                    dec_op   = 3'd6;
                end
`endif
                default: legal = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            instr_q   <= 32'd0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    // Outputs are held at zero while rst is high so a reset landing in
    // WB cannot leak a write strobe in that same cycle.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        retired_d   = retired_q;
        instr_ready = 1'b0;
        rf_ra       = 5'd0;
        rf_rb       = 5'd0;
        rf_re       = 1'b0;
        alu_op      = 3'd0;
        shamt_o     = 5'd0;
        rf_wa       = 5'd0;
        rf_we       = 1'b0;
        illegal     = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    instr_ready = 1'b1;
                    if (instr_valid) begin
                        instr_d = instr;
                        state_d = DECODE;
                    end
                end
                DECODE: begin
                    if (legal) begin
                        state_d = READ;
                    end else begin
                        illegal = 1'b1;
                        state_d = IDLE;
                    end
                end
                READ: begin
                    rf_re   = 1'b1;
                    rf_ra   = is_shift ? rt : rs;
                    rf_rb   = is_shift ? 5'd0 : rt;
                    state_d = EXEC;
                end
                EXEC: begin
                    alu_op  = dec_op;
                    shamt_o = is_shift ? shamt : 5'd0;
                    state_d = WB;
                end
                WB: begin
                    rf_wa     = rd;
                    rf_we     = (rd != 5'd0);
                    retired_d = retired_q + RETIRE_W'(1);
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy    = (state_q != IDLE);
    assign retired = retired_q;

endmodule

// File: tb/tb_rtype_sequencer.sv
// tb_rtype_sequencer: directed stimulus with a per-cycle scoreboard.
// The monitor pops one expected record for every busy cycle.
module tb_rtype_sequencer;

    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_valid;
    logic [31:0]   instr;
    logic          instr_ready;
    logic [4:0]    rf_ra, rf_rb, shamt_o, rf_wa;
    logic          rf_re, rf_we, busy, illegal;
    logic [2:0]    alu_op;
    logic [RW-1:0] retired;

    rtype_sequencer #(.RETIRE_W(RW)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready),
        .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_re(rf_re),
        .alu_op(alu_op), .shamt_o(shamt_o),
        .rf_wa(rf_wa), .rf_we(rf_we),
        .busy(busy), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          re;
        logic [4:0]    ra;
        logic [4:0]    rb;
        logic [2:0]    op;
        logic [4:0]    sh;
        logic [4:0]    wa;
        logic          we;
        logic          ill;
        logic [RW-1:0] ret;
    } rec_t;

    rec_t    sb[$];
    int      total = 0;
    int      bad = 0;
    logic [RW-1:0] m_ret = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic rec_t zrec();
        rec_t r;
        r = '0;
        r.ret = m_ret;
        return r;
    endfunction

    task automatic push_legal(input logic [4:0] ra, input logic [4:0] rb,
                              input logic [2:0] op, input logic [4:0] sh,
                              input logic [4:0] rd);
        rec_t r;
        sb.push_back(zrec());
        r = zrec(); r.re = 1'b1; r.ra = ra; r.rb = rb;
        sb.push_back(r);
        r = zrec(); r.op = op; r.sh = sh;
        sb.push_back(r);
        r = zrec(); r.wa = rd; r.we = (rd != 5'd0);
        sb.push_back(r);
        m_ret = m_ret + 1'b1;
    endtask

    task automatic push_illegal();
        rec_t r;
        r = zrec(); r.ill = 1'b1;
        sb.push_back(r);
    endtask

    initial begin : monitor
        rec_t a, e;
        forever begin
            @(negedge clk);
            if (!rst && busy) begin
                a = '{rf_re, rf_ra, rf_rb, alu_op, shamt_o,
                      rf_wa, rf_we, illegal, retired};
                if (sb.size() == 0) begin
                    chk("unexpected_busy", 64'(a), 64'hdead);
                end else begin
                    e = sb.pop_front();
                    chk("cycle", 64'(a), 64'(e));
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_ready && n < 20);
        if (!instr_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic accept(input logic [31:0] w);
        wait_ready();
        instr_valid = 1'b1;
        instr = w;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = $urandom;
    endtask

    task automatic issue(input logic [31:0] w, input int lat,
                         input string name);
        int n = 0;
        accept(w);
        do begin
            @(negedge clk);
            n++;
        end while (!instr_ready && n < 20);
        chk(name, 64'(n), 64'(lat));
    endtask

    task automatic reset_in(input logic [31:0] w, input int k,
                            input string name);
        accept(w);
        repeat (k) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk({name, "_we"}, 64'(rf_we), 0);
        chk({name, "_op"}, 64'(alu_op), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        m_ret = '0;
        @(negedge clk);
        chk({name, "_idle"}, 64'({instr_ready, busy}), 64'b10);
        chk({name, "_outs"},
            64'({rf_ra, rf_rb, rf_re, alu_op, shamt_o,
                 rf_wa, rf_we, illegal, retired}), 0);
    endtask

    function automatic logic [31:0] rw(input logic [5:0] opc,
        input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
        input logic [4:0] sh, input logic [5:0] fn);
        return {opc, s, t, d, sh, fn};
    endfunction

    logic [5:0] fn_tab [4] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] op_tab [4] = '{3'd1, 3'd2, 3'd3, 3'd4};

    initial begin : stim
        logic [31:0] w;
        int i;
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(instr_ready), 0);
        chk("rst_outs", 64'({busy, illegal, rf_re, rf_we, retired}), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'({instr_ready, busy}), 64'b10);

        // add r2 = r0 + r2
        push_legal(5'd0, 5'd2, 3'd0, 5'd0, 5'd2);
        issue(rw(6'd0, 5'd0, 5'd2, 5'd2, 5'd0, 6'h20), 5, "add_lat");
        chk("add_retired", 64'(retired), 1);

        // sll rd=2 rt=0 shamt=2 with rs unknown
        w = rw(6'd0, 5'd0, 5'd0, 5'd2, 5'd2, 6'h00);
        w[25:21] = 5'bxxxxx;
`ifdef RTYPE_SHIFT_EN
        push_legal(5'd0, 5'd0, 3'd5, 5'd2, 5'd2);
        issue(w, 5, "sll_lat");
        push_legal(5'd3, 5'd0, 3'd6, 5'd7, 5'd4);
        issue(rw(6'd0, 5'd9, 5'd3, 5'd4, 5'd7, 6'h02), 5, "srl_lat");
`else
        push_illegal();
        issue(w, 2, "sll_ill_lat");
        push_illegal();
        issue(rw(6'd0, 5'd9, 5'd3, 5'd4, 5'd7, 6'h02), 2, "srl_ill_lat");
`endif

        push_illegal();
        issue(rw(6'b000100, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 2, "opc_ill");
        push_illegal();
        issue(rw(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h3f), 2, "fn_ill");
        chk("ill_retired", 64'(retired), 64'(m_ret));

        // add with rd=0, shamt nonzero as a don't-care
        push_legal(5'd5, 5'd6, 3'd0, 5'd0, 5'd0);
        issue(rw(6'd0, 5'd5, 5'd6, 5'd0, 5'd17, 6'h20), 5, "rd0_lat");
        chk("rd0_retired", 64'(retired), 64'(m_ret));

        sb.push_back(zrec());
        w = rw(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h22);
        sb.push_back('{1'b1, 5'd1, 5'd2, 3'd0, 5'd0, 5'd0,
                       1'b0, 1'b0, m_ret});
        reset_in(w, 2, "rst_exec");

        sb.push_back(zrec());
        sb.push_back('{1'b1, 5'd1, 5'd2, 3'd0, 5'd0, 5'd0,
                       1'b0, 1'b0, m_ret});
        sb.push_back('{1'b0, 5'd0, 5'd0, 3'd1, 5'd0, 5'd0,
                       1'b0, 1'b0, m_ret});
        reset_in(w, 3, "rst_wb");

        // run retired up to all-ones, then one more wraps to zero
        i = 0;
        while (m_ret != '1) begin
            push_legal(5'(i + 1), 5'(i + 7), op_tab[i % 4],
                       5'd0, 5'(i + 10));
            issue(rw(6'd0, 5'(i + 1), 5'(i + 7), 5'(i + 10),
                     5'(i), fn_tab[i % 4]), 5, "loop_lat");
            i++;
        end
        chk("ones_retired", 64'(retired), 64'({RW{1'b1}}));
        push_legal(5'd8, 5'd9, 3'd4, 5'd0, 5'd31);
        issue(rw(6'd0, 5'd8, 5'd9, 5'd31, 5'd0, 6'h2a), 5, "wrap_lat");
        chk("wrap_retired", 64'(retired), 0);

        chk("sb_empty", 64'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
